// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the inter-stage pipeline latch: state encoding,
// default bubble instruction, and widths of the status outputs.
// -----------------------------------------------------------------------------
package pipe_pkg;

  // Occupancy is 0..2, so two bits; the state encoding equals the occupancy.
  localparam int OCC_W = 2;
  localparam int CNT_W = 16;

  // MIPS "sll $0,$0,0"; zero-extended to the payload width by the latch.
  localparam logic [31:0] NOP_INSN = 32'h0000_0000;

  typedef logic [OCC_W-1:0] state_t;

  localparam state_t ST_EMPTY = 2'd0;  // nothing held
  localparam state_t ST_HALF  = 2'd1;  // main register valid
  localparam state_t ST_FULL  = 2'd2;  // main + skid valid (skid variant only)

  function automatic logic [OCC_W-1:0] occ_of(input state_t s);
    case (s)
      ST_HALF: occ_of = 2'd1;
      ST_FULL: occ_of = 2'd2;
      default: occ_of = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_stage_latch_if.sv
// -----------------------------------------------------------------------------
// pipe_stage_latch_if
// Bundle of the stage-boundary handshake, flush and status signals.
//   master : upstream/downstream/control side (drives in_*, flush, out_ready)
//   slave  : the latch itself
// -----------------------------------------------------------------------------
interface pipe_stage_latch_if #(
  parameter int DATA_W = 64
);
  import pipe_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [OCC_W-1:0]  occupancy;
  logic [CNT_W-1:0]  drop_cnt;

  modport master (
    output in_valid, in_data, flush, out_ready,
    input  in_ready, out_valid, out_data, occupancy, drop_cnt
  );

  modport slave (
    input  in_valid, in_data, flush, out_ready,
    output in_ready, out_valid, out_data, occupancy, drop_cnt
  );

endinterface

// File: rtl/pipe_sat_cnt.sv
// -----------------------------------------------------------------------------
// pipe_sat_cnt
// W-bit counter that adds 0..3 per cycle and sticks at all-ones.
//   clk, rst_n : clock, async active-low reset (count -> 0)
//   inc        : amount to add this cycle
//   cnt        : current count
// -----------------------------------------------------------------------------
module pipe_sat_cnt
  import pipe_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [1:0]   inc,
  output logic [W-1:0] cnt
);

  logic [W:0] sum;

  // One extra bit catches the carry out; a carry means we passed the ceiling.
  assign sum = {1'b0, cnt} + {{(W - 1){1'b0}}, inc};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (sum[W]) begin
      cnt <= '1;
    end else begin
      cnt <= sum[W-1:0];
    end
  end

endmodule

// File: rtl/pipe_stage_latch.sv
// -----------------------------------------------------------------------------
// pipe_stage_latch
// Generic pipeline register for one stage boundary. Carries a DATA_W payload
// with valid/ready handshake, optionally absorbs one stall cycle in a skid
// entry, flushes synchronously to a NOP bubble and counts flushed entries.
//   clk, rst_n : clock, async active-low reset
//   bus        : slave side of pipe_stage_latch_if
//                in_valid/in_ready/in_data   upstream handshake
//                out_valid/out_ready/out_data downstream handshake
//                flush                        kill held and incoming entries
//                occupancy                    entries held (0..2)
//                drop_cnt                     saturating count of flushed entries
// Parameters: SKID_EN=1 gives a registered in_ready (no out_ready->in_ready
// path); SKID_EN=0 gives a single register with combinational ready.
// -----------------------------------------------------------------------------
module pipe_stage_latch
  import pipe_pkg::*;
#(
  parameter int                DATA_W   = 64,
  parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(NOP_INSN),
  parameter bit                SKID_EN  = 1'b1
) (
  input logic              clk,
  input logic              rst_n,
  pipe_stage_latch_if.slave bus
);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              out_valid;
  logic              in_ready;
  logic              accept;
  logic              take;
  logic [OCC_W-1:0]  occ;
  logic [1:0]        drop_inc;

  assign out_valid = (state_q != ST_EMPTY);
  assign occ       = occ_of(state_q);
  assign accept    = bus.in_valid & in_ready;
  assign take      = out_valid & bus.out_ready;

  generate
    if (SKID_EN) begin : g_skid_ready
      // Decoded from state only, so downstream stalls never ripple upstream
      // combinationally; the skid entry catches the one in-flight payload.
      assign in_ready = (state_q != ST_FULL);
    end else begin : g_comb_ready
      assign in_ready = !out_valid | bus.out_ready;
    end
  endgenerate

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_valid ? main_q : NOP_WORD;
  assign bus.occupancy = occ;

  // A taken entry is consumed even in the flush cycle, so it is not a drop.
  assign drop_inc = bus.flush ? (occ + {1'b0, accept} - {1'b0, take}) : 2'd0;

  always_comb begin
    // NOTE: every output of this block gets a default first, so paths that
    // do not assign it hold their value instead of inferring a latch.
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (bus.flush) begin
      state_d = ST_EMPTY;
      main_d  = NOP_WORD;
      skid_d  = NOP_WORD;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d = ST_HALF;
            main_d  = bus.in_data;
          end
        end
        ST_HALF: begin
          if (accept && take) begin
            main_d = bus.in_data;
          end else if (accept && SKID_EN) begin
            state_d = ST_FULL;
            skid_d  = bus.in_data;
          end else if (take) begin
            state_d = ST_EMPTY;
            main_d  = NOP_WORD;
          end
        end
        ST_FULL: begin
          // in_ready is low here, so only the drain can happen.
          if (take) begin
            state_d = ST_HALF;
            main_d  = skid_q;
            skid_d  = NOP_WORD;
          end
        end
        default: begin
          state_d = ST_EMPTY;
          main_d  = NOP_WORD;
          skid_d  = NOP_WORD;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: payload registers are reset too, so out_data and the skid entry
    // start from a known NOP rather than X after power-up.
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      main_q  <= NOP_WORD;
      skid_q  <= NOP_WORD;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values regardless of statement order.
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  pipe_sat_cnt #(
    .W (CNT_W)
  ) u_drop_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (drop_inc),
    .cnt   (bus.drop_cnt)
  );

endmodule
